// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame constants and the bit-period clamp.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_START   = 3'd1,
    TX_DATA    = 3'd2,
    TX_PARITY  = 3'd3,
    TX_STOP    = 3'd4,
    TX_CLEANUP = 3'd5
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_PARITY  = 3'd3,
    RX_STOP    = 3'd4,
    RX_CLEANUP = 3'd5
  } rx_state_e;

  // A period of 0 would never reach its terminal count, so it runs as 1.
  function automatic logic [15:0] clamp_period(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by the UART transmitter and receiver.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load,
  input  logic [15:0] period,
  output logic [15:0] count,
  output logic        end_of_bit
);

  logic [15:0] period_eff;

  assign period_eff = clamp_period(period);
  assign end_of_bit = (count >= (period_eff - 16'd1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= 16'd0;
    end else if (load || end_of_bit) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB-first, one stop bit, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_en,
  input  logic [15:0] CLKS_PER_BIT,
  input  logic        i_Tx_DV,
  input  logic [7:0]  i_Tx_Byte,
  output logic        o_Tx_Ready,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Active,
  output logic        o_Tx_Done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  // Handshake: a byte moves when i_Tx_DV and o_Tx_Ready are both high on a
  // rising clk_i; o_Tx_Ready depends only on the state register and tx_en.

  tx_state_e   state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic [15:0] period_q;
  logic        serial_q;
  logic        active_q;
  logic        done_q;
  logic        accept;
  logic        end_of_bit;
  logic [15:0] unused_bit_count;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  assign o_Tx_Ready  = (state_q == TX_IDLE) & tx_en;
  assign accept      = i_Tx_DV & o_Tx_Ready;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

  uart_bit_timer u_bit_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (accept),
    .period     (period_q),
    .count      (unused_bit_count),
    .end_of_bit (end_of_bit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= TX_IDLE;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      period_q  <= 16'd1;
      serial_q  <= UART_IDLE_LEVEL;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          serial_q <= UART_IDLE_LEVEL;
          active_q <= 1'b0;
          if (accept) begin
            shift_q   <= i_Tx_Byte;
            period_q  <= clamp_period(CLKS_PER_BIT);
            bit_idx_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^i_Tx_Byte;
`endif
            serial_q  <= 1'b0;
            active_q  <= 1'b1;
            state_q   <= TX_START;
          end
        end

        TX_START: begin
          if (end_of_bit) begin
            serial_q <= shift_q[0];
            state_q  <= TX_DATA;
          end
        end

        // serial_q already holds shift_q[0]; at each boundary the next bit is shift_q[1].
        TX_DATA: begin
          if (end_of_bit) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              serial_q <= parity_q;
              state_q  <= TX_PARITY;
`else
              serial_q <= UART_IDLE_LEVEL;
              state_q  <= TX_STOP;
`endif
            end else begin
              serial_q  <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (end_of_bit) begin
            serial_q <= UART_IDLE_LEVEL;
            state_q  <= TX_STOP;
          end
        end
`endif

        TX_STOP: begin
          if (end_of_bit) begin
            active_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= TX_CLEANUP;
          end
        end

        TX_CLEANUP: begin
          serial_q <= UART_IDLE_LEVEL;
          state_q  <= TX_IDLE;
        end

        default: begin
          serial_q <= UART_IDLE_LEVEL;
          active_q <= 1'b0;
          state_q  <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the UART receiver in the peripheral subsystem. Accepts one byte per valid/ready handshake from the bus-side register logic. Sends it LSB-first as an 8N1 frame (optional even-parity bit) at a runtime-programmable bit period. The idle line is held high.

## Interface
- Parameters: none. Bit period is a runtime input. Frame constants live in the package.
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `tx_en` input 1: transmit enable. Gates acceptance of new bytes only.
- `CLKS_PER_BIT` input 16: clocks per bit = f_clk / f_baud. Captured at byte acceptance.
- `i_Tx_DV` input 1: byte valid.
- `i_Tx_Byte` input 8: byte to send.
- `o_Tx_Ready` output 1: block can accept a byte this cycle.
- `o_Tx_Serial` output 1: serial line. Registered; 1 when idle.
- `o_Tx_Active` output 1: frame in progress, from the start bit through the stop bit.
- `o_Tx_Done` output 1: one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP, CLEANUP.
- Accept rule:
  - `o_Tx_Ready` = (state == IDLE) & `tx_en`. This is combinational from the state register.
  - A byte is accepted on a cycle where `i_Tx_DV` & `o_Tx_Ready`.
  - On accept: latch the byte into the shift register, latch `CLKS_PER_BIT` into the period register, clear the bit counter, go to START.
- Bit timer:
  - 16-bit counter runs from 0 to period−1 in each bit state.
  - At period−1 the counter wraps to 0 and the state advances.
  - A latched period of 0 is treated as 1. Every bit lasts at least 1 cycle; no underflow.
- START: drive 0 for one period, then go to DATA.
- DATA:
  - Drive shift-register bit 0.
  - At the end of each period, shift right and increment the 3-bit index.
  - After index 7 completes, go to PARITY (macro on) or STOP.
- STOP: drive 1 for one period. At the end, pulse `o_Tx_Done` and go to CLEANUP.
- CLEANUP: one cycle, line stays 1, go to IDLE.
- `tx_en` deasserted mid-frame: the frame completes normally; no new accepts until `tx_en` returns.
- `CLKS_PER_BIT` changed mid-frame: no effect until the next accept.
- `i_Tx_DV` held high continuously: one byte is accepted per frame, at each return to IDLE.
- Illegal state encoding: go to IDLE with the line at 1.
- Reset:
  - Asserting `rst_i` at any time, including mid-frame, immediately (asynchronously) forces state IDLE.
  - It also forces `o_Tx_Serial`=1, `o_Tx_Active`=0, `o_Tx_Done`=0, and clears the counter, index and shift register.
  - `o_Tx_Ready` follows `tx_en` while in reset-held IDLE. The upstream side must not present data during reset.

## Timing
- Accept edge to `o_Tx_Serial` falling: 1 cycle (registered output).
- `o_Tx_Active` rises in the same cycle the line falls. It falls in the same cycle the stop bit ends.
- `o_Tx_Done` is high for exactly 1 cycle: the CLEANUP cycle, immediately after the last stop-bit cycle.
- Bit boundaries fall exactly N cycles apart, N = latched period. Frame length = 10·N cycles (11·N with parity).
- Accept-to-accept minimum = 10·N + 2 cycles (11·N + 2 with parity): 1 accept cycle, the frame, 1 CLEANUP cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in. It drives the XOR of the 8 latched data bits (even parity) for one period, between data bit 7 and the stop bit.
- Not defined:
  - The PARITY state and the parity logic are absent. DATA goes straight to STOP. The frame is 8N1.
- Port list is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - TX state enum (3-bit) and RX state encodings.
  - `UART_DATA_BITS`=8.
  - Idle-line level constant (1).
  - Helper function for the period clamp (0→1).
- One sub-module, `uart_bit_timer`:
  - Inputs: load, period.
  - Output: a 16-bit counter and an `end_of_bit` strobe.
  - Reusable by the receiver.
- Top level holds the FSM, shift register, bit index and the output registers.

## Test plan
- Reset, `tx_en`=1, `CLKS_PER_BIT`=4, send 0xA5:
  - Line sequence is 0,1,0,1,0,0,1,0,1,1, each level lasting 4 cycles.
  - `o_Tx_Done` pulses once at cycle 41 after accept.
  - `o_Tx_Ready` re-asserts at cycle 42.
- `i_Tx_DV` held high with 0x00 then 0xFF queued (`CLKS_PER_BIT`=3):
  - Two back-to-back frames, 32 cycles apart.
  - Line stays 1 only during the single CLEANUP and accept cycles between them.
- `CLKS_PER_BIT`=0 and then 1, send 0x3C:
  - Each bit lasts 1 cycle; frame is 10 cycles; no hang.
- `tx_en` dropped during data bit 3:
  - The frame completes intact.
  - `o_Tx_Ready` stays 0 and a pending `i_Tx_DV` is not accepted until `tx_en`=1.
- `rst_i` pulsed during data bit 5:
  - Line goes to 1 without waiting for a clock edge; `o_Tx_Active`=0; `o_Tx_Done` never pulses.
  - The next accept produces a clean full frame.
- With `UART_TX_PARITY_EN`, send 0x07 at `CLKS_PER_BIT`=2:
  - Parity bit = 1 for 2 cycles before the stop bit; frame is 22 cycles.
